// File: rtl/mult_sched_pkg.sv
// Shared types and width constants for the multiplier scheduler family.
package mult_sched_pkg;
  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after i_ptr,
// searching circularly. Reusable by any shared-resource scheduler.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_sel;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
      if (w_sum >= (IW + 1)'(N)) w_sum = w_sum - (IW + 1)'(N);
      w_sel = w_sum[IW-1:0];
      if (i_valid[w_sel]) begin
        o_grant        = '0;
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
      end
    end
  end

  assign o_any = |i_valid;
endmodule

// File: rtl/mult8_rr_scheduler.sv
// Round-robin scheduler sharing one external 8x8 multiplier between NUM_REQ
// requesters; one operation in flight, result returned on a valid/ready channel.
module mult8_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 0,
  parameter int ID_W         = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  output logic [OPW-1:0]         mul_a,
  output logic [OPW-1:0]         mul_b,
  input  logic [PW-1:0]          mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PW-1:0]          rsp_p,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output state_e                 dbg_state
);
  localparam int CW = (MULT_LATENCY > 0) ? $clog2(MULT_LATENCY + 1) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload is held while valid && !ready.
  state_e              r_state, w_next;
  logic [OPW-1:0]      r_mul_a, r_mul_b;
  logic [PW-1:0]       r_rsp_p;
  logic [ID_W-1:0]     r_rsp_id, r_rr_ptr;
  logic [CW-1:0]       r_cnt;
  logic                r_rsp_valid;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any, w_accept, w_done, w_hs;
  logic [OPW-1:0]      w_a_arr [NUM_REQ];
  logic [OPW-1:0]      w_b_arr [NUM_REQ];

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_a_arr[g] = req_a[OPW*g +: OPW];
    assign w_b_arr[g] = req_b[OPW*g +: OPW];

    a_hold_operands: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[g] && !req_ready[g]) |=>
        (!req_valid[g] || ($stable(w_a_arr[g]) && $stable(w_b_arr[g]))));
  end

  // req_ready is gated by rst_n so no grant is offered while reset is asserted.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      IDLE: if (rst_n && w_any) begin
        req_ready = w_grant;
        w_accept  = 1'b1;
        w_next    = BUSY;
      end
      BUSY: if (r_cnt == '0) begin
        w_done = 1'b1;
        w_next = RESP;
      end
      RESP: if (rsp_ready) begin
        w_hs   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_p     <= '0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mul_a  <= w_a_arr[w_idx];
        r_mul_b  <= w_b_arr[w_idx];
        r_rsp_id <= w_idx;
        r_rr_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
        r_cnt    <= CW'(MULT_LATENCY);
      end else if (r_state == BUSY && !w_done) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        r_rsp_p     <= mul_p;
        r_rsp_valid <= 1'b1;
      end else if (w_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_mult8_rr_scheduler.sv
// Directed bench for mult8_rr_scheduler: a zero-latency instance with exact or
// nibble-decomposed approximate multiplier, and a latency-2 pipelined instance.
module tb_mult8_rr_scheduler;
  import mult_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- latency-0 instance ----------------
  logic [3:0]  req_valid0 = '0, req_ready0;
  logic [31:0] req_a0 = '0, req_b0 = '0;
  logic [7:0]  mul_a0, mul_b0;
  logic [15:0] mul_p0, rsp_p0, w_exact0, w_approx0;
  logic        rsp_valid0, rsp_ready0 = 1'b1, busy0, use_approx = 1'b0;
  logic [1:0]  rsp_id0;
  state_e      dbg_state0;

  assign w_exact0  = 16'(mul_a0) * 16'(mul_b0);
  assign w_approx0 = w_exact0 - 16'(mul_a0[3:0]) * 16'(mul_b0[3:0]);
  assign mul_p0    = use_approx ? w_approx0 : w_exact0;

  mult8_rr_scheduler #(.NUM_REQ(4), .MULT_LATENCY(0), .ID_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_p(rsp_p0), .rsp_id(rsp_id0),
    .busy(busy0), .dbg_state(dbg_state0)
  );

  // ---------------- latency-2 instance ----------------
  logic [3:0]  req_valid2 = '0, req_ready2;
  logic [31:0] req_a2 = '0, req_b2 = '0;
  logic [7:0]  mul_a2, mul_b2;
  logic [15:0] mul_p2, rsp_p2, pipe_s1, pipe_s2;
  logic        rsp_valid2, busy2;
  logic        rsp_ready2 = 1'b1;
  logic [1:0]  rsp_id2;
  state_e      dbg_state2;

  always @(posedge clk) begin
    pipe_s1 <= 16'(mul_a2) * 16'(mul_b2);
    pipe_s2 <= pipe_s1;
  end
  assign mul_p2 = pipe_s2;

  mult8_rr_scheduler #(.NUM_REQ(4), .MULT_LATENCY(2), .ID_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_p(rsp_p2), .rsp_id(rsp_id2),
    .busy(busy2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard / helpers ----------------
  logic [15:0] exp_q[$];
  logic [1:0]  exp_id_q[$];

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Four nibble partial products with the low x low term dropped.
  function automatic logic [15:0] nr_model(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ah, al, bh, bl;
    ah = 16'(a[7:4]); al = 16'(a[3:0]);
    bh = 16'(b[7:4]); bl = 16'(b[3:0]);
    return ((ah * bh) << 8) + ((ah * bl + al * bh) << 4);
  endfunction

  task automatic wait_rsp0(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (rsp_valid0) ok = 1'b1;
    end
  endtask

  // Called with dut0 in IDLE, 1 time unit after a rising edge, rsp_ready0=1.
  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    req_a0[8*id +: 8] = a;
    req_b0[8*id +: 8] = b;
    req_valid0 = oh;
    #1;
    check({nm, "_ready"}, 32'(req_ready0), 32'(oh));
    @(posedge clk); #1;
    req_valid0 = '0;
    check({nm, "_busy_ops"}, {busy0, rsp_valid0, mul_a0, mul_b0}, {1'b1, 1'b0, a, b});
    @(posedge clk); #1;
    check({nm, "_rsp_valid"}, 32'(rsp_valid0), 32'd1);
    check({nm, "_rsp_p"}, 32'(rsp_p0), 32'(exp_p));
    check({nm, "_rsp_id"}, 32'(rsp_id0), 32'(id));
    @(posedge clk); #1;
    check({nm, "_idle"}, {rsp_valid0, dbg_state0}, {1'b0, IDLE});
  endtask

  initial begin
    bit          ok;
    int          prev_cyc;
    logic [7:0]  ra, rb;
    int          rid;

    vecs[0] = '{2, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{0, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{1, 8'd128, 8'd2,   16'd256};
    vecs[3] = '{3, 8'd0,   8'd77,  16'd0};
    vecs[4] = '{3, 8'd1,   8'd200, 16'd200};
    vecs[5] = '{1, 8'd200, 8'd3,   16'd600};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy0, rsp_valid0, rsp_id0, rsp_p0, mul_a0, mul_b0},
          {1'b0, 1'b0, 2'd0, 16'd0, 8'd0, 8'd0});
    check("reset_state", {req_ready0, dbg_state0, busy2, rsp_valid2}, {4'd0, IDLE, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of single requests
    for (int i = 0; i < 6; i++)
      single_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Dropped request is skipped: rr_ptr is 3 after granting 2, but 3 drops out.
    req_a0[23:16] = 8'd5; req_b0[23:16] = 8'd6;
    req_valid0 = 4'b0100;
    @(posedge clk); #1;
    req_a0[31:24] = 8'd9; req_b0[31:24] = 8'd9;
    req_a0[7:0]   = 8'd2; req_b0[7:0]   = 8'd3;
    req_valid0 = 4'b1001;
    @(posedge clk); #1;
    check("drop_first_rsp", {rsp_valid0, rsp_id0, rsp_p0}, {1'b1, 2'd2, 16'd30});
    req_valid0 = 4'b0001;
    @(posedge clk); #1;
    check("drop_grant", 32'(req_ready0), 32'b0001);
    @(posedge clk); #1;
    req_valid0 = '0;
    @(posedge clk); #1;
    check("drop_rsp", {rsp_valid0, rsp_id0, rsp_p0}, {1'b1, 2'd0, 16'd6});
    @(posedge clk); #1;

    // Backpressure in RESP
    rsp_ready0 = 1'b0;
    req_a0[15:8] = 8'd7; req_b0[15:8] = 8'd9;
    req_valid0 = 4'b0010;
    @(posedge clk); #1;
    req_a0[23:16] = 8'd10; req_b0[23:16] = 8'd10;
    req_valid0 = 4'b0100;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), {rsp_valid0, rsp_id0, rsp_p0, req_ready0},
            {1'b1, 2'd1, 16'd63, 4'd0});
      @(posedge clk); #1;
    end
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {rsp_valid0, dbg_state0, req_ready0}, {1'b0, IDLE, 4'b0100});
    @(posedge clk); #1;
    req_valid0 = '0;
    @(posedge clk); #1;
    check("bp_next_rsp", {rsp_valid0, rsp_id0, rsp_p0}, {1'b1, 2'd2, 16'd100});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of BUSY
    req_a0 = {8'd1, 8'd0, 8'd128, 8'd255};
    req_b0 = {8'd200, 8'd77, 8'd2, 8'd255};
    req_valid0 = 4'b1000;
    @(posedge clk); #1;
    check("rst_pre_busy", {busy0, rsp_id0}, {1'b1, 2'd3});
    #1;
    rst_n = 1'b0;
    req_valid0 = 4'b1111;
    #1;
    check("rst_async_outputs", {busy0, rsp_valid0, rsp_id0, rsp_p0, mul_a0, mul_b0},
          {1'b0, 1'b0, 2'd0, 16'd0, 8'd0, 8'd0});
    check("rst_async_ready", {req_ready0, dbg_state0}, {4'd0, IDLE});
    @(posedge clk); #1;
    check("rst_no_rsp", {rsp_valid0, busy0}, {1'b0, 1'b0});
    rst_n = 1'b1;

    // All four valid: grant order 0,1,2,3,0 with 3-cycle spacing
    exp_q    = '{16'd65025, 16'd256, 16'd0, 16'd200, 16'd65025};
    exp_id_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp0(20, ok);
      check($sformatf("rr%0d_timeout", k), 32'(ok), 32'd1);
      if (!ok) break;
      check($sformatf("rr%0d_id", k), 32'(rsp_id0), 32'(exp_id_q.pop_front()));
      check($sformatf("rr%0d_p", k), 32'(rsp_p0), 32'(exp_q.pop_front()));
      if (k > 0) check($sformatf("rr%0d_spacing", k), 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
    end
    req_valid0 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rr_idle", {dbg_state0, rsp_valid0}, {IDLE, 1'b0});

    // Latency-2 pipelined multiplier
    req_a2[15:8] = 8'd200; req_b2[15:8] = 8'd3;
    req_valid2 = 4'b0010;
    #1;
    check("lat2_ready", 32'(req_ready2), 32'b0010);
    @(posedge clk); #1;
    req_valid2 = '0;
    check("lat2_accept", {busy2, rsp_valid2, mul_a2, mul_b2}, {1'b1, 1'b0, 8'd200, 8'd3});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("lat2_busy%0d", i), {busy2, rsp_valid2, mul_a2, mul_b2, req_ready2},
            {1'b1, 1'b0, 8'd200, 8'd3, 4'd0});
    end
    @(posedge clk); #1;
    check("lat2_rsp", {rsp_valid2, rsp_id2, rsp_p2}, {1'b1, 2'd1, 16'd600});
    @(posedge clk); #1;
    check("lat2_idle", {rsp_valid2, dbg_state2}, {1'b0, IDLE});

    // Approximate datapath with random operands and requesters
    use_approx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rid = $urandom_range(0, 3);
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      single_op(rid, ra, rb, nr_model(ra, rb), $sformatf("approx%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
